seg7_scan_driver: RTL and testbench
===================================

// Module: seg7_scan_driver
// PURPOSE
//   Multi-digit, time-multiplexed seven-segment display driver; parametrised successor of single-segment decoders.
//   Holds DIGITS 4-bit values, decodes each to a 7-segment pattern (hex or BCD) and scans digits round-robin.
//   New values enter through a valid/ready handshake and commit atomically at a frame boundary (no tearing).
//   Optional leading-zero blanking and a one-cycle anti-ghost gap on every digit change.
// PARAMETERS
//   DIGITS      4     number of digits scanned (>=1)
//   SCAN_DIV    1000  clk cycles per digit slot (>=2)
//   HEX_MODE    1     1: values A-F decode as A,b,C,d,E,F; 0: BCD, values 10-15 show blank
//   ACTIVE_LOW  0     1: seg and dig_en are inverted at the pins (lit = 0)
// PORTS
//   clk         in   1          system clock, all logic on rising edge
//   rst         in   1          synchronous, active-high reset
//   load_valid  in   1          load_data is valid
//   load_ready  out  1          block can accept a new frame
//   load_data   in   4*DIGITS   digit i value = load_data[4*i+3:4*i]; digit 0 = least significant
//   lz_blank    in   1          1: blank leading zeros (sampled every cycle)
//   seg         out  7          seg[0]=a ... seg[6]=g
//   dig_en      out  DIGITS     one-hot digit enable
// BEHAVIOUR
// - Reset (rst=1 at an edge):
//   - seg, dig_en all unlit (0, or all 1 if ACTIVE_LOW).
//   - load_ready=1; div=0; idx=0; display and shadow registers = 0; pending=0.
//   - Any pending load is discarded.
// - Scan:
//   - div counts 0..SCAN_DIV-1. At div==SCAN_DIV-1: div->0 and idx advances.
//   - idx wraps DIGITS-1 -> 0; that transition is the frame wrap.
// - Outputs are registered, one-cycle latency: seg/dig_en at cycle t+1 reflect idx/div/display/lz_blank at t.
// - dig_en:
//   - div==0: all unlit (anti-ghost gap).
//   - Otherwise: only bit idx lit.
// - seg = decode(display[idx]) with fixed patterns (bit6..0 = g..a):
//   - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F
//   - A:77 b:7C C:39 d:5E E:79 F:71
//   - HEX_MODE=0: values 10-15 -> 00 (blank).
// - Leading-zero blank: with lz_blank=1, digit i>0 shows 00 if display[i] and all higher digits are 0.
//   Digit 0 is never blanked.
// - Handshake / FSM (states RUN, PEND):
//   - RUN: load_ready=1. load_valid=1 copies load_data to shadow, sets pending, next state PEND.
//   - PEND: load_ready=0; load_valid ignored.
//   - PEND, at the frame wrap edge: shadow -> display, pending=0, back to RUN.
//     The new values first appear on the registered outputs for digit 0 of the new frame.
//   - Accept and frame wrap on the same edge: data goes to shadow only; commit at the following wrap (about one frame later).
//   - Commit latency is therefore between 1 and DIGITS*SCAN_DIV cycles after the accept.
// - The display register changes only at the frame wrap, so every frame shows one coherent value set.
// - rst asserted mid-frame or mid-PEND: immediate return to reset state at that edge; no partial commit.
// - DIGITS=1: every slot end is a frame wrap; idx stays 0.
// TESTING (DIGITS=4, SCAN_DIV=4, HEX_MODE=1, ACTIVE_LOW=0 unless noted)
// 1. Reset, then run one frame
//    -> dig_en sequence per slot is 0000,0001x3, 0000,0010x3, ... 1000x3.
//    -> seg=3F while lit (all zeros, lz_blank=0).
// 2. Load 16'h1A2F while idle
//    -> load_ready low the next cycle.
//    -> From the next frame: digits 0..3 show 71,5B,77,06.
//    -> load_ready high again after the commit.
// 3. load_valid held high while PEND with changing data
//    -> only the first accepted value is ever displayed.
//    -> No accept occurs while load_ready=0.
// 4. Accept on the exact frame-wrap edge
//    -> old values persist for the whole next frame; new values commit at the wrap after that.
// 5. lz_blank=1 with display 16'h0050
//    -> digits 3 and 2 seg=00, digit 1 seg=6D, digit 0 seg=3F.
//    -> Display 16'h0000 -> only digit 0 shows 3F.
// 6. HEX_MODE=0 with value C on digit 2 -> seg=00 for that digit.
//    ACTIVE_LOW=1 -> seg and dig_en inverted vs scenario 1.
//    rst pulse during PEND -> outputs unlit, load_ready=1, display back to 0.

Source files
------------

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_driver
// Purpose  : Time-multiplexed driver for a DIGITS-digit seven-segment display.
//            Holds one 4-bit value per digit and decodes it to a segment
//            pattern (hex, or BCD with 10-15 blank). Digits are scanned
//            round-robin, each for SCAN_DIV cycles. The first cycle of every
//            slot is a dark gap so the previous digit cannot ghost. New values
//            arrive over a valid/ready handshake and are committed only at
//            the frame wrap, so a frame never mixes old and new digits.
//            Optional leading-zero blanking.
// Ports    : clk        - system clock, rising edge
//            rst        - synchronous active-high reset
//            load_valid - load_data carries a new frame
//            load_ready - a new frame can be accepted
//            load_data  - digit i = load_data[4*i+3:4*i], digit 0 = LSD
//            lz_blank   - blank leading zeros (sampled every cycle)
//            seg        - segments, seg[0]=a .. seg[6]=g
//            dig_en     - one-hot digit enable
// Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_driver #(
  parameter int DIGITS     = 4,
  parameter int SCAN_DIV   = 1000,
  parameter int HEX_MODE   = 1,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [4*DIGITS-1:0]   load_data,
  input  logic                  lz_blank,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     dig_en
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [6:0]        SEG_OFF  = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [DIGITS-1:0] DIG_OFF  = (ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    PEND = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [4*DIGITS-1:0]   display_q, display_d;
  logic [4*DIGITS-1:0]   shadow_q, shadow_d;
  logic [6:0]            seg_q, seg_d;
  logic [DIGITS-1:0]     dig_en_q, dig_en_d;

  logic                  slot_end;
  logic                  frame_wrap;
  logic [3:0]            cur_val;
  logic                  nz_acc;
  logic                  higher_nz;
  logic                  blank;
  logic [DIGITS-1:0]     onehot;
  logic [6:0]            seg_raw;
  logic [DIGITS-1:0]     dig_raw;

  // Fixed segment table, bit6..0 = g..a.
  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] p;
    case (v)
      4'h0: p = 7'h3F;
      4'h1: p = 7'h06;
      4'h2: p = 7'h5B;
      4'h3: p = 7'h4F;
      4'h4: p = 7'h66;
      4'h5: p = 7'h6D;
      4'h6: p = 7'h7D;
      4'h7: p = 7'h07;
      4'h8: p = 7'h7F;
      4'h9: p = 7'h6F;
      4'hA: p = 7'h77;
      4'hB: p = 7'h7C;
      4'hC: p = 7'h39;
      4'hD: p = 7'h5E;
      4'hE: p = 7'h79;
      default: p = 7'h71;
    endcase
    if ((HEX_MODE == 0) && (v > 4'h9)) begin
      p = 7'h00;
    end
    return p;
  endfunction

  // Scan counters and load/commit FSM.
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    idx_d     = idx_q;
    display_d = display_q;
    shadow_d  = shadow_q;

    slot_end   = (div_q == DIV_LAST);
    frame_wrap = slot_end && (idx_q == IDX_LAST);

    if (slot_end) begin
      div_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end else begin
      div_d = div_q + DIV_W'(1);
    end

    case (state_q)
      RUN: begin
        // An accept on the wrap edge lands in shadow only; the commit
        // waits for the next wrap so this frame stays coherent.
        if (load_valid) begin
          shadow_d = load_data;
          state_d  = PEND;
        end
      end
      PEND: begin
        if (frame_wrap) begin
          display_d = shadow_q;
          state_d   = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Output pattern for the digit currently addressed by idx.
  always_comb begin
    cur_val   = 4'h0;
    nz_acc    = 1'b0;
    higher_nz = 1'b0;
    onehot    = '0;
    // Walk from the most significant digit down, accumulating whether any
    // digit at or above the current position is non-zero.
    for (int i = DIGITS - 1; i >= 0; i--) begin
      nz_acc = nz_acc | (display_q[4*i +: 4] != 4'h0);
      if (idx_q == IDX_W'(i)) begin
        cur_val   = display_q[4*i +: 4];
        higher_nz = nz_acc;
        onehot[i] = 1'b1;
      end
    end

    // Digit 0 always shows, so a zero value still displays as "0".
    blank   = lz_blank && (idx_q != '0) && !higher_nz;
    seg_raw = blank ? 7'h00 : decode(cur_val);
    dig_raw = (div_q == '0) ? '0 : onehot;

    seg_d    = (ACTIVE_LOW != 0) ? ~seg_raw : seg_raw;
    dig_en_d = (ACTIVE_LOW != 0) ? ~dig_raw : dig_raw;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      div_q     <= '0;
      idx_q     <= '0;
      display_q <= '0;
      shadow_q  <= '0;
      seg_q     <= SEG_OFF;
      dig_en_q  <= DIG_OFF;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      idx_q     <= idx_d;
      display_q <= display_d;
      shadow_q  <= shadow_d;
      seg_q     <= seg_d;
      dig_en_q  <= dig_en_d;
    end
  end

  assign load_ready = (state_q == RUN);
  assign seg        = seg_q;
  assign dig_en     = dig_en_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_scan_driver
// Purpose  : Scoreboard bench for seg7_scan_driver. Two instances share the
//            inputs: A (hex, active-high) and B (BCD, active-low). A cycle-
//            count reference model predicts every output cycle into a queue;
//            a monitor on the falling edge pops and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_driver;

  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 4;
  localparam int FRAME    = DIGITS * SCAN_DIV;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_valid;
  logic [15:0] load_data;
  logic        lz_blank;
  logic        ready_a, ready_b;
  logic [6:0]  seg_a, seg_b;
  logic [3:0]  en_a, en_b;

  always #5 clk = ~clk;

  seg7_scan_driver #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .HEX_MODE(1), .ACTIVE_LOW(0)) u_dut_a (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(ready_a),
    .load_data(load_data), .lz_blank(lz_blank), .seg(seg_a), .dig_en(en_a)
  );

  seg7_scan_driver #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .HEX_MODE(0), .ACTIVE_LOW(1)) u_dut_b (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(ready_b),
    .load_data(load_data), .lz_blank(lz_blank), .seg(seg_b), .dig_en(en_b)
  );

  typedef struct packed {
    logic [6:0] seg_a;
    logic [3:0] en_a;
    logic [6:0] seg_b;
    logic [3:0] en_b;
    logic       ready;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state: edges since reset, committed and pending digits.
  int   cnt;
  int   disp[DIGITS];
  int   shadow[DIGITS];
  bit   pend;
  int   pos, slot, ph, v;
  bit   zero_above, blk;
  exp_t e;

  function automatic logic [6:0] pat(input int val);
    case (val)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h6F; 10: return 7'h77; 11: return 7'h7C;
      12: return 7'h39; 13: return 7'h5E; 14: return 7'h79; 15: return 7'h71;
      default: return 7'h00;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      cnt  = 0;
      pend = 0;
      for (int i = 0; i < DIGITS; i++) begin
        disp[i]   = 0;
        shadow[i] = 0;
      end
      e.seg_a = 7'h00;
      e.en_a  = 4'h0;
      e.seg_b = 7'h7F;
      e.en_b  = 4'hF;
      e.ready = 1'b1;
    end else begin
      pos  = cnt % FRAME;
      slot = pos / SCAN_DIV;
      ph   = pos % SCAN_DIV;
      zero_above = 1;
      for (int j = slot; j < DIGITS; j++) if (disp[j] != 0) zero_above = 0;
      blk = lz_blank && (slot > 0) && zero_above;
      v   = disp[slot];
      e.seg_a = blk ? 7'h00 : pat(v);
      e.seg_b = ~((blk || v > 9) ? 7'h00 : pat(v));
      e.en_a  = (ph != 0) ? 4'(1 << slot) : 4'h0;
      e.en_b  = ~e.en_a;
      if (pend && pos == FRAME - 1) begin
        for (int i = 0; i < DIGITS; i++) disp[i] = shadow[i];
        pend = 0;
      end else if (!pend && load_valid) begin
        for (int i = 0; i < DIGITS; i++) shadow[i] = int'(load_data[4*i +: 4]);
        pend = 1;
      end
      cnt++;
      e.ready = !pend;
    end
    sb.push_back(e);
  end

  // Monitor: every output cycle is compared against the next prediction.
  always @(negedge clk) begin
    exp_t x;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      n_cmp++;
      if (seg_a !== x.seg_a || en_a !== x.en_a) begin
        n_bad++;
        $display("FAIL out_a t=%0t seg=%h dig_en=%b expected seg=%h dig_en=%b",
                 $time, seg_a, en_a, x.seg_a, x.en_a);
      end
      n_cmp++;
      if (seg_b !== x.seg_b || en_b !== x.en_b) begin
        n_bad++;
        $display("FAIL out_b t=%0t seg=%h dig_en=%b expected seg=%h dig_en=%b",
                 $time, seg_b, en_b, x.seg_b, x.en_b);
      end
      n_cmp++;
      if (ready_a !== x.ready || ready_b !== x.ready) begin
        n_bad++;
        $display("FAIL load_ready t=%0t a=%b b=%b expected %b",
                 $time, ready_a, ready_b, x.ready);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (pend && k < 2 * FRAME + 4) begin
      @(negedge clk);
      k++;
    end
    if (pend) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_ready timeout t=%0t pending=%b expected 0", $time, pend);
    end
  endtask

  task automatic do_load(input logic [15:0] d);
    wait_idle();
    load_valid = 1'b1;
    load_data  = d;
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  initial begin
    int k;
    rst        = 1'b1;
    load_valid = 1'b0;
    load_data  = 16'h0;
    lz_blank   = 1'b0;
    cycles(3);
    rst = 1'b0;

    // Free-running frame of zeros.
    cycles(FRAME + 2);

    // Basic load and commit.
    do_load(16'h1A2F);
    cycles(2 * FRAME);

    // Valid held high with changing data.
    wait_idle();
    load_valid = 1'b1;
    repeat (2 * FRAME) begin
      load_data = 16'($urandom);
      @(negedge clk);
    end
    load_valid = 1'b0;
    cycles(2 * FRAME);

    // Accept exactly on the frame-wrap edge.
    k = 0;
    while ((pend || (cnt % FRAME) != FRAME - 1) && k < 4 * FRAME) begin
      @(negedge clk);
      k++;
    end
    if (pend || (cnt % FRAME) != FRAME - 1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wrap_align timeout t=%0t pos=%0d expected %0d", $time, cnt % FRAME, FRAME - 1);
    end
    load_valid = 1'b1;
    load_data  = 16'h3B7E;
    @(negedge clk);
    load_valid = 1'b0;
    cycles(3 * FRAME);

    // Leading-zero blanking.
    lz_blank = 1'b1;
    do_load(16'h0050);
    cycles(2 * FRAME + 2);
    do_load(16'h0000);
    cycles(2 * FRAME + 2);
    lz_blank = 1'b0;

    // BCD blanking of value C on digit 2 (instance B).
    do_load(16'h0C98);
    cycles(2 * FRAME + 2);

    // Reset while a load is pending.
    do_load(16'h1234);
    cycles(2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cycles(FRAME + 2);

    // Randomized traffic with occasional resets.
    repeat (1500) begin
      load_valid = ($urandom_range(0, 5) == 0);
      load_data  = 16'($urandom);
      lz_blank   = $urandom_range(0, 1) != 0;
      rst        = ($urandom_range(0, 249) == 0);
      @(negedge clk);
    end
    rst        = 1'b0;
    load_valid = 1'b0;
    cycles(2 * FRAME);

    @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
